box_sprite_drawer: RTL and testbench

- Sits directly downstream of the processor stage and upstream of the VGA adapter.
- Consumes xpos[7:0], ypos[6:0] and the plot strobe from the processor stage.
- On each plot request it erases the previously drawn box in background colour, then draws a BOX_SIZE x BOX_SIZE box at the new position.
- Emits one pixel write per cycle (x, y, colour, write enable) to the VGA adapter.

---
 rtl/box_draw_pkg.sv | 18 +
 rtl/box_sprite_drawer_if.sv | 26 ++
 rtl/pixel_scan_counter.sv | 36 +++
 rtl/box_sprite_drawer.sv | 154 +++++++++++++++
 tb/tb_box_sprite_drawer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/box_draw_pkg.sv
// Shared types and widths for the box sprite drawer.
package box_draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int X_MAX_DEFAULT = 159;
    localparam int Y_MAX_DEFAULT = 119;

    // IDLE: nothing in progress. ERASE/DRAW: scan whose next pixel is to be issued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/box_sprite_drawer_if.sv
// Request side (from the processor stage) and pixel side (to the VGA adapter).
interface box_sprite_drawer_if;
    import box_draw_pkg::*;

    logic [X_W-1:0]      xpos;
    logic [Y_W-1:0]      ypos;
    logic                plot;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;
    logic                busy;
    logic                done;

    // Upstream driver of requests, consumer of the pixel stream.
    modport master (
        output xpos, ypos, plot,
        input  vga_x, vga_y, vga_colour, vga_write, busy, done
    );

    // The drawer itself.
    modport slave (
        input  xpos, ypos, plot,
        output vga_x, vga_y, vga_colour, vga_write, busy, done
    );
endinterface

// File: rtl/pixel_scan_counter.sv
// Row-major dx/dy walker over a BOX_SIZE x BOX_SIZE box. dx/dy name the pixel
// that will be issued at the next enabled edge; it wraps to 0 after the last
// pixel so back-to-back scans start without a bubble.
module pixel_scan_counter #(
    parameter int BOX_SIZE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       en,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);
    localparam logic [3:0] EDGE_MAX = 4'(BOX_SIZE - 1);

    assign last = (dx == EDGE_MAX) && (dy == EDGE_MAX);

    // Hold at pixel 0 while no scan is active, otherwise step dx inner, dy outer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (start || (en && last)) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            if (dx == EDGE_MAX) begin
                dx <= '0;
                dy <= dy + 4'd1;
            end else begin
                dx <= dx + 4'd1;
            end
        end
    end
endmodule

// File: rtl/box_sprite_drawer.sv
// Erase-then-draw box sprite engine: one registered pixel write per cycle.
module box_sprite_drawer
    import box_draw_pkg::*;
#(
    parameter int                  BOX_SIZE  = 4,
    parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
    parameter int                  X_MAX     = X_MAX_DEFAULT,
    parameter int                  Y_MAX     = Y_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    box_sprite_drawer_if.slave bus
);
    state_t state_reg, state_next, issue_phase;
    logic   finish_reg;       // the pixel on the outputs now is the last DRAW pixel
    logic   have_prev_reg, pending_reg;
    logic [X_W-1:0] old_x_reg, new_x_reg, queued_x_reg, base_x;
    logic [Y_W-1:0] old_y_reg, new_y_reg, queued_y_reg, base_y;
    logic [3:0]     dx, dy;
    logic           scan_last, issue_valid, pend_any, draw_ends;
    logic [X_W:0]   pix_x;
    logic [Y_W:0]   pix_y;
    logic           pix_visible;

    logic [X_W-1:0]      x_next;
    logic [Y_W-1:0]      y_next;
    logic [COLOUR_W-1:0] colour_next;
    logic                write_next, busy_next, done_next;

    pixel_scan_counter #(.BOX_SIZE(BOX_SIZE)) u_scan (
        .clk   (clk),
        .reset (reset),
        .start (!issue_valid),
        .en    (issue_valid),
        .dx    (dx),
        .dy    (dy),
        .last  (scan_last)
    );

    // Decide which scan (if any) issues a pixel at this edge. The edge right
    // after a finished draw never issues: it carries the done pulse.
    always_comb begin
        issue_phase = IDLE;
        if (!finish_reg) begin
            if (state_reg == IDLE) begin
                if (bus.plot) issue_phase = have_prev_reg ? ERASE : DRAW;
            end else begin
                issue_phase = state_reg;
            end
        end
    end

    assign issue_valid = (issue_phase != IDLE);
    assign pend_any    = pending_reg | bus.plot;
    assign draw_ends   = issue_valid && scan_last && (issue_phase == DRAW);

    // Base of the box being scanned; a draw started straight from IDLE uses the live request.
    always_comb begin
        base_x = new_x_reg;
        base_y = new_y_reg;
        if (issue_phase == ERASE) begin
            base_x = old_x_reg;
            base_y = old_y_reg;
        end else if (state_reg == IDLE) begin
            base_x = bus.xpos;
            base_y = bus.ypos;
        end
    end

    assign pix_x       = {1'b0, base_x} + {{(X_W - 3){1'b0}}, dx};
    assign pix_y       = {1'b0, base_y} + {{(Y_W - 3){1'b0}}, dy};
    assign pix_visible = (pix_x <= (X_W + 1)'(X_MAX)) && (pix_y <= (Y_W + 1)'(Y_MAX));

    // Next-state and next registered outputs.
    always_comb begin
        state_next  = state_reg;
        x_next      = '0;
        y_next      = '0;
        colour_next = '0;
        write_next  = 1'b0;
        busy_next   = issue_valid || (finish_reg && pend_any);
        done_next   = finish_reg;
        if (finish_reg) begin
            state_next = pend_any ? ERASE : IDLE;
        end else if (issue_valid) begin
            x_next      = pix_x[X_W-1:0];
            y_next      = pix_y[Y_W-1:0];
            colour_next = (issue_phase == ERASE) ? BG_COLOUR : FG_COLOUR;
            write_next  = pix_visible;
            if (!scan_last)                 state_next = issue_phase;
            else if (issue_phase == ERASE)  state_next = DRAW;
            else                            state_next = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            finish_reg     <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_write  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            finish_reg     <= draw_ends;
            bus.vga_x      <= x_next;
            bus.vga_y      <= y_next;
            bus.vga_colour <= colour_next;
            bus.vga_write  <= write_next;
            bus.busy       <= busy_next;
            bus.done       <= done_next;
        end
    end

    // Position bookkeeping: live, queued (last request wins) and previously drawn box.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            have_prev_reg <= 1'b0;
            pending_reg   <= 1'b0;
            old_x_reg     <= '0;
            old_y_reg     <= '0;
            new_x_reg     <= '0;
            new_y_reg     <= '0;
            queued_x_reg  <= '0;
            queued_y_reg  <= '0;
        end else if (finish_reg) begin
            pending_reg <= 1'b0;
            if (pend_any) begin
                new_x_reg <= bus.plot ? bus.xpos : queued_x_reg;
                new_y_reg <= bus.plot ? bus.ypos : queued_y_reg;
            end
        end else begin
            if (bus.plot && (state_reg == IDLE)) begin
                new_x_reg <= bus.xpos;
                new_y_reg <= bus.ypos;
            end
            if (bus.plot && (state_reg != IDLE)) begin
                pending_reg  <= 1'b1;
                queued_x_reg <= bus.xpos;
                queued_y_reg <= bus.ypos;
            end
            if (draw_ends) begin
                old_x_reg     <= base_x;
                old_y_reg     <= base_y;
                have_prev_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_box_sprite_drawer.sv
// Scoreboard bench for box_sprite_drawer: expected pixels are queued when a
// plot is driven and checked as the drawer emits them.
module tb_box_sprite_drawer;
    localparam int BOX = 4;
    typedef logic [18:0] pix_t;   // {x[7:0], y[6:0], colour[2:0], write}

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    pix_t exp_q[$];
    pix_t obs_pix, exp_pix;

    box_sprite_drawer_if bus ();

    box_sprite_drawer #(
        .BOX_SIZE  (BOX),
        .FG_COLOUR (3'b111),
        .BG_COLOUR (3'b000),
        .X_MAX     (159),
        .Y_MAX     (119)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pixel cycle (busy, not done) pops one expected pixel.
    always @(negedge clk) begin
        if (!reset && bus.busy && !bus.done) begin
            obs_pix = {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_extra got x=%0d y=%0d c=%0d w=%0d, expected none",
                         bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write);
            end else begin
                exp_pix = exp_q.pop_front();
                if (obs_pix !== exp_pix) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d w=%0d, expected x=%0d y=%0d c=%0d w=%0d",
                             obs_pix[18:11], obs_pix[10:4], obs_pix[3:1], obs_pix[0],
                             exp_pix[18:11], exp_pix[10:4], exp_pix[3:1], exp_pix[0]);
                end else begin
                    $display("pixel x=%0d y=%0d c=%0d w=%0d ok",
                             obs_pix[18:11], obs_pix[10:4], obs_pix[3:1], obs_pix[0]);
                end
            end
        end else if (!reset && !bus.busy) begin
            checks++;
            if (bus.vga_write !== 1'b0 || bus.vga_colour !== 3'b000) begin
                failures++;
                $display("FAIL idle_quiet got w=%0d c=%0d, expected w=0 c=0",
                         bus.vga_write, bus.vga_colour);
            end
        end
    end

    // Queue the first n pixels of a scan at (bx,by).
    task automatic push_scan(input int bx, input int by, input logic [2:0] col, input int n);
        int px;
        int py;
        for (int k = 0; k < n; k++) begin
            px = bx + k % BOX;
            py = by + k / BOX;
            exp_q.push_back({8'(px), 7'(py), col, (px <= 159) && (py <= 119)});
        end
    endtask

    task automatic do_plot(input int x, input int y);
        @(negedge clk);
        bus.xpos = 8'(x);
        bus.ypos = 7'(y);
        bus.plot = 1'b1;
        @(posedge clk);
        #1 bus.plot = 1'b0;
    endtask

    // Measures one redraw from the cycle after the plot edge up to its done pulse.
    task automatic wait_redraw(output int busy_cycles, output int done_at,
                               output logic busy_at_done, output int first_busy);
        busy_cycles  = 0;
        done_at      = -1;
        first_busy   = -1;
        busy_at_done = 1'bx;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_at      = c;
                busy_at_done = bus.busy;
                break;
            end else if (bus.busy) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = c;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.plot = 1'b0;
        bus.xpos = '0;
        bus.ypos = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, bus.busy, bus.done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got x=%0d y=%0d c=%0d w=%0d busy=%0d done=%0d, expected all 0",
                     bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, bus.busy, bus.done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One redraw whose expected pixels are already queued.
    task automatic check_redraw(input string name, input int exp_busy);
        int busy_cycles, done_at, first_busy;
        logic busy_at_done;
        wait_redraw(busy_cycles, done_at, busy_at_done, first_busy);
        checks++;
        if (first_busy !== 1) begin
            failures++;
            $display("FAIL %s_first_pixel got cycle %0d, expected 1", name, first_busy);
        end
        checks++;
        if (busy_cycles !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy_cycles got %0d, expected %0d", name, busy_cycles, exp_busy);
        end
        checks++;
        if (done_at !== exp_busy + 1 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done got cycle %0d busy=%0d, expected cycle %0d busy=0",
                     name, done_at, busy_at_done, exp_busy + 1);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_width got done=%0d busy=%0d, expected 0 0", name, bus.done, bus.busy);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s_missing got %0d pixels left, expected 0", name, exp_q.size());
        end
        $display("redraw %s busy=%0d done_at=%0d", name, busy_cycles, done_at);
    endtask

    task automatic test_first_plot();
        push_scan(10, 20, 3'b111, BOX * BOX);
        do_plot(10, 20);
        check_redraw("first_plot", BOX * BOX);
    endtask

    task automatic test_move();
        push_scan(10, 20, 3'b000, BOX * BOX);
        push_scan(11, 20, 3'b111, BOX * BOX);
        do_plot(11, 20);
        check_redraw("move", 2 * BOX * BOX);
    endtask

    task automatic test_same_position();
        push_scan(11, 20, 3'b000, BOX * BOX);
        push_scan(11, 20, 3'b111, BOX * BOX);
        do_plot(11, 20);
        check_redraw("same_pos", 2 * BOX * BOX);
    endtask

    task automatic test_clip();
        pulse_reset();
        push_scan(158, 118, 3'b111, BOX * BOX);
        do_plot(158, 118);
        check_redraw("clip", BOX * BOX);
    endtask

    task automatic test_back_to_back();
        int pix_cycles = 0;
        int dones = 0;
        int done1 = -1;
        int done2 = -1;
        logic busy1 = 1'bx;
        logic busy2 = 1'bx;
        pulse_reset();
        push_scan(10, 20, 3'b111, BOX * BOX);
        push_scan(10, 20, 3'b000, BOX * BOX);
        push_scan(40, 50, 3'b111, BOX * BOX);
        do_plot(10, 20);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (dones == 1) begin done1 = c; busy1 = bus.busy; end
                else begin done2 = c; busy2 = bus.busy; end
            end else if (bus.busy) begin
                pix_cycles++;
            end
            if (c == 4)  begin bus.xpos = 8'd30; bus.ypos = 7'd30; bus.plot = 1'b1; end
            if (c == 5)  bus.plot = 1'b0;
            if (c == 8)  begin bus.xpos = 8'd40; bus.ypos = 7'd50; bus.plot = 1'b1; end
            if (c == 9)  bus.plot = 1'b0;
            if (dones == 2 || c > 80) break;
        end
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL b2b_done_count got %0d, expected 2", dones);
        end
        checks++;
        if (done1 !== 17 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap got done cycle %0d busy=%0d, expected cycle 17 busy=1", done1, busy1);
        end
        checks++;
        if (done2 !== 50 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final_done got cycle %0d busy=%0d, expected cycle 50 busy=0", done2, busy2);
        end
        checks++;
        if (pix_cycles !== 3 * BOX * BOX || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_pixels got %0d cycles %0d left, expected 48 cycles 0 left",
                     pix_cycles, exp_q.size());
        end
        $display("back_to_back dones=%0d done1=%0d done2=%0d", dones, done1, done2);
    endtask

    task automatic test_reset_mid_erase();
        push_scan(40, 50, 3'b000, 4);
        do_plot(20, 30);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.vga_write, bus.busy, bus.done, bus.vga_colour} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async got w=%0d busy=%0d done=%0d c=%0d, expected all 0",
                     bus.vga_write, bus.busy, bus.done, bus.vga_colour);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_erase_pixels got %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
        push_scan(5, 5, 3'b111, BOX * BOX);
        do_plot(5, 5);
        check_redraw("after_reset", BOX * BOX);
    endtask

    initial begin
        bus.plot = 1'b0;
        bus.xpos = '0;
        bus.ypos = '0;
        test_reset();
        test_first_plot();
        test_move();
        test_same_position();
        test_clip();
        test_back_to_back();
        test_reset_mid_erase();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
